dh_link_arbiter: RTL and testbench

//  Multi-drone to command-centre message arbiter for the DH key-exchange link.

---
 rtl/dh_link_arbiter_if.sv | 33 +++
 rtl/dh_link_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dh_link_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dh_link_arbiter_if.sv
// Message bundle between the drone channels, the DH link arbiter and the command centre.
// The slave side is the arbiter; the master side is whatever drives the drones and the CC.
interface dh_link_arbiter_if #(
    parameter int N          = 8,
    parameter int NUM_DRONES = 4
);
    localparam int ID_W = (NUM_DRONES > 1) ? $clog2(NUM_DRONES) : 1;

    logic [NUM_DRONES-1:0]     drone_mess_rdy;
    logic [NUM_DRONES*2*N-1:0] drone_mess_out;
    logic [NUM_DRONES-1:0]     drone_wait_for_cc;
    logic [NUM_DRONES-1:0]     drone_received;
    logic [NUM_DRONES*N-1:0]   drone_mess_input;
    logic                      cc_drone_rdy;
    logic [2*N-1:0]            cc_mess_input;
    logic [ID_W-1:0]           cc_drone_id;
    logic                      cc_mess_rdy;
    logic [N-1:0]              cc_mess_out;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        output drone_mess_rdy, drone_mess_out, cc_mess_rdy, cc_mess_out,
        input  drone_wait_for_cc, drone_received, drone_mess_input,
               cc_drone_rdy, cc_mess_input, cc_drone_id, busy, timeout_err
    );

    modport slave (
        input  drone_mess_rdy, drone_mess_out, cc_mess_rdy, cc_mess_out,
        output drone_wait_for_cc, drone_received, drone_mess_input,
               cc_drone_rdy, cc_mess_input, cc_drone_id, busy, timeout_err
    );
endinterface

// File: rtl/dh_link_arbiter.sv
// Round-robin arbiter routing one drone's DH public-value message at a time to the
// command centre and returning the CC reply to that drone only, with a reply timeout.
// Every output is a register, updated together with the FSM state.
module dh_link_arbiter #(
    parameter int N          = 8,
    parameter int NUM_DRONES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    dh_link_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_DRONES > 1) ? $clog2(NUM_DRONES) : 1;
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DELIVER} state_t;

    state_t                  state, state_n;
    logic [ID_W-1:0]         rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]         grant, grant_n;
    logic [TW-1:0]           timer, timer_n;
    logic [NUM_DRONES-1:0]   wait_q, wait_n;
    logic [NUM_DRONES-1:0]   recv_q, recv_n;
    logic [NUM_DRONES*N-1:0] reply_q, reply_n;
    logic                    cc_rdy_q, cc_rdy_n;
    logic [2*N-1:0]          cc_msg_q, cc_msg_n;
    logic                    busy_q, busy_n;
    logic                    tmo_q, tmo_n;

    logic [NUM_DRONES-1:0]   req_rot;
    logic                    req_found;
    logic [ID_W-1:0]         req_off;
    logic [ID_W:0]           req_sum;
    logic [ID_W-1:0]         req_idx;
    logic [2*N-1:0]          req_msg;
    logic [ID_W-1:0]         grant_inc;
    logic [TW-1:0]           timer_inc;

    // Rotating the request vector by rr_ptr turns the round-robin search into a lowest-set-bit search.
    assign req_rot   = NUM_DRONES'({bus.drone_mess_rdy, bus.drone_mess_rdy} >> rr_ptr);
    assign req_sum   = {1'b0, rr_ptr} + {1'b0, req_off};
    assign req_idx   = (req_sum >= (ID_W+1)'(NUM_DRONES)) ? ID_W'(req_sum - (ID_W+1)'(NUM_DRONES))
                                                          : ID_W'(req_sum);
    assign grant_inc = (grant == ID_W'(NUM_DRONES - 1)) ? '0 : grant + 1'b1;
    assign timer_inc = timer + 1'b1;

    // Find the first requester at or after rr_ptr (descending scan leaves the lowest offset).
    always_comb begin
        req_found = 1'b0;
        req_off   = '0;
        for (int k = NUM_DRONES - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                req_found = 1'b1;
                req_off   = ID_W'(k);
            end
        end
    end

    // Select the message of the drone about to be granted.
    always_comb begin
        req_msg = '0;
        for (int i = 0; i < NUM_DRONES; i++) begin
            if (req_idx == ID_W'(i)) begin
                req_msg = bus.drone_mess_out[i*2*N +: 2*N];
            end
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        grant_n  = grant;
        timer_n  = timer;
        wait_n   = wait_q;
        recv_n   = '0;
        reply_n  = reply_q;
        cc_rdy_n = 1'b0;
        cc_msg_n = cc_msg_q;
        tmo_n    = 1'b0;
        case (state)
            IDLE: begin
                if (req_found) begin
                    state_n  = SEND;
                    grant_n  = req_idx;
                    cc_msg_n = req_msg;
                    timer_n  = '0;
                    cc_rdy_n = 1'b1;
                    wait_n   = NUM_DRONES'(1) << req_idx;
                end
            end
            SEND: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.cc_mess_rdy) begin
                    state_n = DELIVER;
                    recv_n  = NUM_DRONES'(1) << grant;
                    reply_n = '0;
                    for (int i = 0; i < NUM_DRONES; i++) begin
                        if (grant == ID_W'(i)) begin
                            reply_n[i*N +: N] = bus.cc_mess_out;
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    timer_n = timer_inc;
                    if (timer_inc == TW'(TIMEOUT)) begin
                        state_n  = IDLE;
                        tmo_n    = 1'b1;
                        rr_ptr_n = grant_inc;
                        wait_n   = '0;
                    end
                end
            end
            DELIVER: begin
                state_n  = IDLE;
                rr_ptr_n = grant_inc;
                wait_n   = '0;
                reply_n  = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers: reset clears everything, ena=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            timer    <= '0;
            wait_q   <= '0;
            recv_q   <= '0;
            reply_q  <= '0;
            cc_rdy_q <= 1'b0;
            cc_msg_q <= '0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else if (ena) begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            grant    <= grant_n;
            timer    <= timer_n;
            wait_q   <= wait_n;
            recv_q   <= recv_n;
            reply_q  <= reply_n;
            cc_rdy_q <= cc_rdy_n;
            cc_msg_q <= cc_msg_n;
            busy_q   <= busy_n;
            tmo_q    <= tmo_n;
        end
    end

    assign bus.drone_wait_for_cc = wait_q;
    assign bus.drone_received    = recv_q;
    assign bus.drone_mess_input  = reply_q;
    assign bus.cc_drone_rdy      = cc_rdy_q;
    assign bus.cc_mess_input     = cc_msg_q;
    assign bus.cc_drone_id       = grant;
    assign bus.busy              = busy_q;
    assign bus.timeout_err       = tmo_q;
endmodule

// File: tb/tb_dh_link_arbiter.sv
// Testbench for dh_link_arbiter: a timeline-driven stimulus task pushes expected CC sends,
// drone deliveries and timeouts into a queue; a negedge monitor pops and compares them.
module tb_dh_link_arbiter;
    localparam int N          = 8;
    localparam int ND         = 4;
    localparam int TMO        = 10;
    localparam int ID_W       = 2;
    localparam int FREEZE_LEN = 20;

    typedef struct {
        int             kind;
        int             id;
        int             cycle;
        logic [2*N-1:0] msg;
        logic [ND*N-1:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   model_rr = 0;
    int   idle_from = 0;
    ev_t  exp_q[$];

    dh_link_arbiter_if #(.N(N), .NUM_DRONES(ND)) bus ();

    dh_link_arbiter #(.N(N), .NUM_DRONES(ND), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    // Free-running clock and cycle counter; cycle c lies between posedge c and posedge c+1.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp every expected event.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Round-robin rule: first requester at model_rr, model_rr+1, ... modulo ND.
    function automatic int modelGrant(input logic [ND-1:0] mask);
        for (int k = 0; k < ND; k++) begin
            if (mask[(model_rr + k) % ND]) return (model_rr + k) % ND;
        end
        return 0;
    endfunction

    task automatic matchEvent(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        checkOutput("event_kind", 64'(kind), 64'(e.kind));
        checkOutput("event_cycle", 64'(cyc), 64'(e.cycle));
        case (kind)
            0: begin
                checkOutput("send_id", 64'(bus.cc_drone_id), 64'(e.id));
                checkOutput("send_msg", 64'(bus.cc_mess_input), 64'(e.msg));
                checkOutput("send_wait_onehot", 64'(bus.drone_wait_for_cc), 64'(1) << e.id);
            end
            1: begin
                checkOutput("recv_onehot", 64'(bus.drone_received), 64'(1) << e.id);
                checkOutput("recv_data", 64'(bus.drone_mess_input), 64'(e.vec));
                checkOutput("recv_wait_onehot", 64'(bus.drone_wait_for_cc), 64'(1) << e.id);
            end
            default: begin
                checkOutput("tmo_busy", 64'(bus.busy), 64'(0));
                checkOutput("tmo_wait_clear", 64'(bus.drone_wait_for_cc), 64'(0));
            end
        endcase
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cc_drone_rdy) matchEvent(0);
            if (bus.drone_received != '0) matchEvent(1);
            if (bus.timeout_err) matchEvent(2);
        end
    end

    task automatic checkResetOutputs();
        checkOutput("rst_wait_for_cc", 64'(bus.drone_wait_for_cc), 64'(0));
        checkOutput("rst_received", 64'(bus.drone_received), 64'(0));
        checkOutput("rst_mess_input", 64'(bus.drone_mess_input), 64'(0));
        checkOutput("rst_cc_drone_rdy", 64'(bus.cc_drone_rdy), 64'(0));
        checkOutput("rst_cc_mess_input", 64'(bus.cc_mess_input), 64'(0));
        checkOutput("rst_cc_drone_id", 64'(bus.cc_drone_id), 64'(0));
        checkOutput("rst_busy", 64'(bus.busy), 64'(0));
        checkOutput("rst_timeout_err", 64'(bus.timeout_err), 64'(0));
    endtask

    // One exchange. delay = WAIT cycles before the CC strobe (<0 or >=TMO: CC silent);
    // freeze >= 0 drops ena for FREEZE_LEN cycles starting at that WAIT cycle index.
    task automatic applyStimulus(input logic [ND-1:0] mask, input int gap, input int delay,
                                 input logic [N-1:0] reply, input int freeze,
                                 input bit use_fixed, input logic [2*N-1:0] fixed_msg);
        int  t;
        int  g;
        int  u;
        int  f0;
        int  shift;
        ev_t e;
        t = idle_from + gap;
        waitUntil(t);
        for (int i = 0; i < ND; i++) bus.drone_mess_out[i*2*N +: 2*N] = (2*N)'($urandom);
        g = modelGrant(mask);
        if (use_fixed) bus.drone_mess_out[g*2*N +: 2*N] = fixed_msg;
        bus.drone_mess_rdy = mask;
        e.kind = 0; e.id = g; e.cycle = t + 1;
        e.msg = bus.drone_mess_out[g*2*N +: 2*N]; e.vec = '0;
        exp_q.push_back(e);
        waitUntil(t + 1);
        bus.drone_mess_rdy = '0;
        for (int i = 0; i < ND; i++) bus.drone_mess_out[i*2*N +: 2*N] = (2*N)'($urandom);
        bus.cc_mess_rdy = 1'($urandom);
        bus.cc_mess_out = N'($urandom);
        waitUntil(t + 2);
        bus.cc_mess_rdy = 1'b0;
        shift = 0;
        if (freeze >= 0) begin
            f0 = t + 2 + freeze;
            waitUntil(f0);
            ena = 1'b0;
            for (int k = 1; k <= FREEZE_LEN; k++) begin
                bus.cc_mess_rdy = 1'($urandom);
                waitUntil(f0 + k);
                checkOutput("frz_wait_for_cc", 64'(bus.drone_wait_for_cc), 64'(1) << g);
                checkOutput("frz_busy", 64'(bus.busy), 64'(1));
                checkOutput("frz_timeout_err", 64'(bus.timeout_err), 64'(0));
                checkOutput("frz_received", 64'(bus.drone_received), 64'(0));
            end
            ena = 1'b1;
            bus.cc_mess_rdy = 1'b0;
            shift = FREEZE_LEN;
        end
        if (delay >= 0 && delay < TMO) begin
            u = t + 2 + delay + shift;
            waitUntil(u);
            bus.cc_mess_rdy = 1'b1;
            bus.cc_mess_out = reply;
            e.kind = 1; e.id = g; e.cycle = u + 1; e.msg = '0;
            e.vec = '0; e.vec[g*N +: N] = reply;
            exp_q.push_back(e);
            waitUntil(u + 1);
            bus.cc_mess_rdy = 1'b0;
            bus.cc_mess_out = N'($urandom);
            idle_from = u + 2;
        end else begin
            e.kind = 2; e.id = g; e.cycle = t + 2 + TMO + shift; e.msg = '0; e.vec = '0;
            exp_q.push_back(e);
            idle_from = t + 2 + TMO + shift;
        end
        model_rr = (g + 1) % ND;
    endtask

    // Start an exchange for drone 1, then reset for two cycles in the middle of WAIT.
    task automatic applyMidReset();
        int  t;
        ev_t e;
        t = idle_from;
        waitUntil(t);
        bus.drone_mess_rdy = 4'b0010;
        e.kind = 0; e.id = modelGrant(4'b0010); e.cycle = t + 1;
        e.msg = bus.drone_mess_out[e.id*2*N +: 2*N]; e.vec = '0;
        exp_q.push_back(e);
        waitUntil(t + 1);
        bus.drone_mess_rdy = '0;
        waitUntil(t + 4);
        rst = 1'b1;
        bus.drone_mess_rdy = '1;
        waitUntil(t + 6);
        rst = 1'b0;
        checkResetOutputs();
        model_rr  = 0;
        idle_from = t + 6;
    endtask

    initial begin
        logic [ND-1:0] mask;
        int            gap;
        int            delay;
        int            freeze;
        rst = 1'b1;
        ena = 1'b1;
        bus.drone_mess_rdy = '0;
        bus.drone_mess_out = '0;
        bus.cc_mess_rdy    = 1'b0;
        bus.cc_mess_out    = '0;
        waitUntil(3);
        rst = 1'b0;
        checkResetOutputs();
        idle_from = 3;

        for (int r = 0; r < 6; r++) applyStimulus(4'hF, 0, 0, N'($urandom), -1, 1'b0, '0);
        for (int r = 0; r < 4; r++) applyStimulus(4'b1010, 0, 0, N'($urandom), -1, 1'b0, '0);

        applyStimulus(4'b0100, 1, 4, 8'h3C, -1, 1'b1, 16'hA55A);

        applyStimulus(4'b0001, 2, -1, '0, -1, 1'b0, '0);
        applyStimulus(4'b0011, 0, 1, 8'h81, -1, 1'b0, '0);

        applyStimulus(4'b1000, 0, TMO - 1, 8'h5A, -1, 1'b0, '0);

        applyStimulus(4'b0100, 1, 5, 8'hC3, 3, 1'b0, '0);
        applyStimulus(4'b0001, 0, -1, '0, 4, 1'b0, '0);

        applyMidReset();
        applyStimulus(4'hF, 0, 2, 8'h77, -1, 1'b0, '0);

        for (int i = 0; i < 60; i++) begin
            mask  = ND'($urandom_range(1, 15));
            gap   = $urandom_range(0, 3);
            delay = $urandom_range(0, TMO + 2);
            if (delay >= TMO) delay = -1;
            freeze = -1;
            if ($urandom_range(0, 7) == 0) freeze = $urandom_range(0, (delay < 0) ? TMO - 1 : delay);
            applyStimulus(mask, gap, delay, N'($urandom), freeze, 1'b0, '0);
        end

        waitUntil(idle_from + 3);
        checkOutput("pending_events", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
